// File: rtl/gray_pkg.sv
// gray_pkg: width-generic binary/Gray conversions shared by the counter and Gray-pointer receivers.
package gray_pkg;
    localparam int MAX_W = 64;
    typedef logic [MAX_W-1:0] vec_t;
    function automatic vec_t bin2gray(input vec_t b);
        return b ^ (b >> 1);
    endfunction
    // Zero-extended inputs decode correctly because the prefix XOR runs from the MSB down.
    function automatic vec_t gray2bin(input vec_t g);
        vec_t b;
        b[MAX_W-1] = g[MAX_W-1];
        for (int i = MAX_W - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction
endpackage

// File: rtl/gray_to_bin.sv
// gray_to_bin: combinational WIDTH-bit Gray-to-binary decoder.
module gray_to_bin
    import gray_pkg::*;
#(
    parameter int WIDTH = 3
) (
    input  logic [WIDTH-1:0] gray_i,
    output logic [WIDTH-1:0] bin_o
);
    assign bin_o = WIDTH'(gray2bin(vec_t'(gray_i)));
endmodule

// File: rtl/gray_counter.sv
// gray_counter: registered up/down binary+Gray counter with binary or Gray load.
// Define GRAY_COUNTER_SAT_EN to saturate at the limits instead of wrapping.
module gray_counter
    import gray_pkg::*;
#(
    parameter int               WIDTH   = 3,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic             load_gray,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray,
    output logic             wrap
);
    typedef logic [WIDTH-1:0] cnt_t;
`ifdef GRAY_COUNTER_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif
    localparam cnt_t RST_GRAY = cnt_t'(bin2gray(vec_t'(RST_VAL)));
    cnt_t bin_q, bin_d, gray_q, gray_d, dec_bin, step_bin;
    logic wrap_q, wrap_d, at_lim;
    gray_to_bin #(.WIDTH(WIDTH)) u_dec (
        .gray_i (load_val),
        .bin_o  (dec_bin)
    );
    // at_lim: the next step in the requested direction would cross the end of the range
    always_comb begin
        at_lim   = up_dn ? &bin_q : ~|bin_q;
        step_bin = (SAT && at_lim) ? bin_q : (up_dn ? bin_q + cnt_t'(1) : bin_q - cnt_t'(1));
        bin_d    = load ? (load_gray ? dec_bin : load_val) : (en ? step_bin : bin_q);
        gray_d   = cnt_t'(bin2gray(vec_t'(bin_d)));
        wrap_d   = !load && en && at_lim;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_q  <= RST_VAL;
            gray_q <= RST_GRAY;
            wrap_q <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            gray_q <= gray_d;
            wrap_q <= wrap_d;
        end
    end
    assign bin  = bin_q;
    assign gray = gray_q;
    assign wrap = wrap_q;
endmodule
